pll_prog_divider: RTL and testbench

Programmable feedback divider for the fractional-N PLL, directly downstream of the delta-sigma modulator top. Counts VCO-rate `Clk` cycles and divides by the 8-bit ratio the modulator produces. Once per output period, latches a new ratio and emits a one-cycle `Load_Strobe` that the modulator uses to advance to its next sample. `Div_Out` is the divided clock delivered to the phase-frequency detector.

---
 rtl/pll_prog_divider.sv | 113 +++++++++++
 tb/tb_pll_prog_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pll_prog_divider.sv
// pll_prog_divider
//   Programmable feedback divider for the fractional-N PLL. Counts Clk cycles
//   and divides by the (clamped) ratio supplied by the delta-sigma modulator.
//   It loads a new ratio once per output period and pulses Load_Strobe for one
//   cycle on each load.
//
//   Optional feature macro: DIV_DUTY50_EN
//     defined     -> Div_Out is high ceil(ratio/2) and low floor(ratio/2) cycles
//     not defined -> Div_Out is a single-cycle pulse equal to Load_Strobe
//
// Ports
//   Clk          VCO-rate clock, rising edge
//   reset        asynchronous active-low reset
//   Enable       run request; low parks the divider in IDLE
//   Div_In       requested divide ratio, sampled only on load edges
//   Div_Out      divided clock to the PFD (registered)
//   Load_Strobe  one-cycle pulse at each ratio load / period start (registered)
//   Ratio_Out    ratio currently in effect after clamping (registered)
module pll_prog_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_MIN = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Div_In,
  output logic             Div_Out,
  output logic             Load_Strobe,
  output logic [WIDTH-1:0] Ratio_Out
);

  localparam logic [WIDTH-1:0] NMIN = WIDTH'(N_MIN);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] ratio_next;
  logic             div_out_next;
  logic             load_strobe_next;

  logic [WIDTH-1:0] div_clamp;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] cnt_dec;
  logic             load;

  // Clamp requested ratio up to the minimum legal value
  assign div_clamp = (Div_In < NMIN) ? NMIN : Div_In;

  // Number of high cycles per period
`ifdef DIV_DUTY50_EN
  assign high_time = (ratio >> 1) + WIDTH'(ratio[0]);
`else
  assign high_time = ONE;
`endif

  assign cnt_dec = cnt - ONE;
  assign load    = Enable && ((state == IDLE) || (cnt == '0));

  // Next-state and output decode
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    ratio_next       = ratio;
    div_out_next     = 1'b0;
    load_strobe_next = 1'b0;

    if (load) begin
      state_next       = RUN;
      ratio_next       = div_clamp;
      cnt_next         = div_clamp - ONE;
      div_out_next     = 1'b1;
      load_strobe_next = 1'b1;
    end else if (state == RUN) begin
      if (Enable) begin
        cnt_next     = cnt_dec;
        // ratio - cnt_next is the 1-based position in the period; the load
        // cycle is position 1, so positions 1..high_time are driven high
        div_out_next = (ratio - cnt_dec) <= high_time;
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ratio       <= NMIN;
      Div_Out     <= 1'b0;
      Load_Strobe <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ratio       <= ratio_next;
      Div_Out     <= div_out_next;
      Load_Strobe <= load_strobe_next;
    end
  end

  assign Ratio_Out = ratio;

endmodule

// File: tb/tb_pll_prog_divider.sv
// Directed bench for pll_prog_divider (default parameters WIDTH=8, N_MIN=8).
module tb_pll_prog_divider;

  logic       Clk = 1'b0;
  logic       reset;
  logic       Enable;
  logic [7:0] Div_In;
  logic       Div_Out;
  logic       Load_Strobe;
  logic [7:0] Ratio_Out;

  int n_tests = 0;
  int n_fail  = 0;

  pll_prog_divider #(.WIDTH(8), .N_MIN(8)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .Enable     (Enable),
    .Div_In     (Div_In),
    .Div_Out    (Div_Out),
    .Load_Strobe(Load_Strobe),
    .Ratio_Out  (Ratio_Out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_high(input int r);
`ifdef DIV_DUTY50_EN
    return (r + 1) / 2;
`else
    return 1;
`endif
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Called while a strobe cycle is visible; walks to the next strobe,
  // measuring period length and Div_Out high cycles. Optionally changes
  // Div_In at a given position inside the period.
  task automatic run_period(input string tag, input int exp_len,
                            input int change_at, input logic [7:0] new_val);
    int len;
    int high;
    bit done;
    len  = 1;
    high = int'(Div_Out);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (len == change_at) Div_In = new_val;
      step();
      if (Load_Strobe) done = 1'b1;
      else begin
        len++;
        high += int'(Div_Out);
      end
    end
    if (!done) check({tag, " timeout"}, 0, 1);
    check({tag, " period"}, len, exp_len);
    check({tag, " high"}, high, exp_high(exp_len));
  endtask

  initial begin
    reset  = 1'b0;
    Enable = 1'b0;
    Div_In = 8'd20;
    repeat (3) step();
    check("rst div_out", int'(Div_Out), 0);
    check("rst strobe", int'(Load_Strobe), 0);
    check("rst ratio", int'(Ratio_Out), 8);

    reset = 1'b1;
    step();
    check("idle strobe", int'(Load_Strobe), 0);
    check("idle ratio", int'(Ratio_Out), 8);

    // Start-up with constant 20
    Enable = 1'b1;
    step();
    check("start strobe", int'(Load_Strobe), 1);
    check("start div_out", int'(Div_Out), 1);
    check("start ratio", int'(Ratio_Out), 20);
    run_period("p20a", 20, -1, 8'd0);
    check("p20a ratio", int'(Ratio_Out), 20);

    // 21 sampled at the end of this 20-cycle period
    Div_In = 8'd21;
    run_period("p20b", 20, -1, 8'd0);
    check("p21 ratio", int'(Ratio_Out), 21);

    // Below minimum clamps to 8
    Div_In = 8'd3;
    run_period("p21", 21, -1, 8'd0);
    check("clamp ratio", int'(Ratio_Out), 8);

    Div_In = 8'd255;
    run_period("p8", 8, -1, 8'd0);
    check("p255 ratio", int'(Ratio_Out), 255);

    // Mid-period change 16 -> 40 must not disturb the running period
    Div_In = 8'd16;
    run_period("p255", 255, -1, 8'd0);
    check("p16 ratio", int'(Ratio_Out), 16);
    run_period("p16", 16, 5, 8'd40);
    check("p40 ratio", int'(Ratio_Out), 40);

    Div_In = 8'd30;
    run_period("p40", 40, -1, 8'd0);
    check("p30 ratio", int'(Ratio_Out), 30);

    // Enable low at cycle 5 of a 30-cycle period
    repeat (4) step();
    Enable = 1'b0;
    step();
    check("dis div_out", int'(Div_Out), 0);
    check("dis strobe", int'(Load_Strobe), 0);
    check("dis ratio", int'(Ratio_Out), 30);
    step();
    check("dis strobe2", int'(Load_Strobe), 0);
    Enable = 1'b1;
    step();
    check("reen strobe", int'(Load_Strobe), 1);
    check("reen div_out", int'(Div_Out), 1);
    run_period("p30 reen", 30, -1, 8'd0);

    // Asynchronous reset mid-period
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("arst div_out", int'(Div_Out), 0);
    check("arst strobe", int'(Load_Strobe), 0);
    check("arst ratio", int'(Ratio_Out), 8);
    step();
    reset = 1'b1;
    step();
    check("rel strobe", int'(Load_Strobe), 1);
    check("rel ratio", int'(Ratio_Out), 30);
    run_period("p30 rel", 30, -1, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
